discharge_supervisor: RTL and testbench

DISCHARGE_SUPERVISOR -- requirements
Module: discharge_supervisor

---
 rtl/discharge_supervisor_pkg.sv | 19 +
 rtl/toggle_sync_capture.sv | 48 ++++
 rtl/discharge_supervisor.sv | 147 ++++++++++++++
 tb/tb_discharge_supervisor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/discharge_supervisor_pkg.sv
// Shared constants for the discharge supervisor: state encoding and default parameters.
package discharge_supervisor_pkg;

    localparam int unsigned NUM_SRC_DEF     = 2;
    localparam int unsigned NUM_PARAM_DEF   = 4;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DRAIN_MAX_DEF   = 10000;
    localparam int unsigned DRAIN_CNT_W     = 16;
    localparam int unsigned STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STOPPING = 3'd2,
        ST_FAULT    = 3'd3
    } state_t;

endpackage

// File: rtl/toggle_sync_capture.sv
// One parameter channel: toggle synchroniser, edge detect and pending capture register.
module toggle_sync_capture
    import discharge_supervisor_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_async,
    input  logic              apply,
    output logic              pending,
    output logic [DATA_W-1:0] pending_data
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   capture_c;

    assign capture_c = sync_q[SYNC_STAGES-1] ^ edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A capture in the same cycle as an apply keeps the flag set for the newer word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            pending_data <= '0;
        end else begin
            if (capture_c) begin
                pending_data <= data_async;
                pending      <= 1'b1;
            end else if (apply) begin
                pending      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/discharge_supervisor.sv
// Start/stop arbitration, parameter hand-over and run/stop/fault sequencing for the pulse generator.
module discharge_supervisor
    import discharge_supervisor_pkg::*;
#(
    parameter int unsigned NUM_SRC     = NUM_SRC_DEF,
    parameter int unsigned NUM_PARAM   = NUM_PARAM_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DRAIN_MAX   = DRAIN_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_start,
    input  logic [NUM_SRC-1:0]            src_stop,
    input  logic [NUM_PARAM-1:0]          param_req_tgl,
    input  logic [NUM_PARAM*DATA_W-1:0]   param_data_async,
    input  logic                          cycle_done,
    input  logic                          pulse_busy,
    input  logic                          fault_in,
    input  logic                          fault_clr,
    output logic                          is_machine,
    output logic [NUM_PARAM*DATA_W-1:0]   param_active,
    output logic [NUM_PARAM-1:0]          param_pending,
    output logic [STATE_W-1:0]            state,
    output logic                          fault_latched,
    output logic                          drain_timeout
);

    state_t                 state_q;
    state_t                 state_nxt;
    logic [NUM_SRC-1:0]     en_q;
    logic [NUM_PARAM-1:0]   loaded_q;
    logic [NUM_PARAM-1:0]   apply_c;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q;
    logic [DATA_W-1:0]      pend_data [NUM_PARAM];
    logic                   run_req_c;
    logic                   apply_window_c;
    logic                   drain_hit_c;
    logic                   timeout_c;
    logic                   clear_c;

    assign state          = state_q;
    assign run_req_c      = &en_q;
    assign drain_hit_c    = (drain_cnt_q == DRAIN_CNT_W'(DRAIN_MAX - 1));
    // Outside RUN/STOPPING nothing is consuming parameters, so pending words go straight through.
    assign apply_window_c = (state_q == ST_IDLE) || (state_q == ST_FAULT) || cycle_done;
    assign apply_c        = param_pending & {NUM_PARAM{apply_window_c}};

    for (genvar i = 0; i < NUM_PARAM; i++) begin : g_ch
        toggle_sync_capture #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cap (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_tgl      (param_req_tgl[i]),
            .data_async   (param_data_async[i*DATA_W +: DATA_W]),
            .apply        (apply_c[i]),
            .pending      (param_pending[i]),
            .pending_data (pend_data[i])
        );
    end

    // Source enable latches: stop beats start, fault clears all, starts ignored while faulted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
        end else if (fault_in) begin
            en_q <= '0;
        end else begin
            en_q <= (en_q | (src_start & {NUM_SRC{state_q != ST_FAULT}})) & ~src_stop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            param_active <= '0;
            loaded_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_PARAM; i++) begin
                if (apply_c[i]) begin
                    param_active[i*DATA_W +: DATA_W] <= pend_data[i];
                    loaded_q[i]                      <= 1'b1;
                end
            end
        end
    end

    // Next-state logic; a fault overrides every other transition.
    always_comb begin
        state_nxt = state_q;
        timeout_c = 1'b0;
        clear_c   = 1'b0;
        if (fault_in) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_req_c && (&loaded_q) && !fault_latched) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!run_req_c) state_nxt = ST_STOPPING;
                end
                ST_STOPPING: begin
                    if (!pulse_busy) begin
                        state_nxt = ST_IDLE;
                    end else if (drain_hit_c) begin
                        state_nxt = ST_IDLE;
                        timeout_c = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_nxt = ST_IDLE;
                        clear_c   = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            is_machine    <= 1'b0;
            drain_cnt_q   <= '0;
            fault_latched <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            is_machine  <= (state_nxt == ST_RUN);
            drain_cnt_q <= (state_q == ST_STOPPING) ? drain_cnt_q + DRAIN_CNT_W'(1) : '0;
            if (fault_in) begin
                fault_latched <= 1'b1;
            end else if (clear_c) begin
                fault_latched <= 1'b0;
            end
            if (clear_c) begin
                drain_timeout <= 1'b0;
            end else if (timeout_c) begin
                drain_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_discharge_supervisor.sv
// Scoreboard bench for discharge_supervisor: directed stimulus queues timed expectations, a negedge monitor checks them.
module tb_discharge_supervisor;
    import discharge_supervisor_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned NP = 4;
    localparam int unsigned DW = 16;

    localparam int K_STATE = 0;
    localparam int K_MACH  = 1;
    localparam int K_ACT   = 2;
    localparam int K_PEND  = 3;
    localparam int K_FLT   = 4;
    localparam int K_DTO   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NS-1:0]       src_start;
    logic [NS-1:0]       src_stop;
    logic [NP-1:0]       param_req_tgl;
    logic [NP*DW-1:0]    param_data_async;
    logic                cycle_done;
    logic                pulse_busy;
    logic                fault_in;
    logic                fault_clr;
    logic                is_machine;
    logic [NP*DW-1:0]    param_active;
    logic [NP-1:0]       param_pending;
    logic [2:0]          state;
    logic                fault_latched;
    logic                drain_timeout;

    typedef struct {
        string       name;
        int unsigned at;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] got;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] vals [4];

    discharge_supervisor #(
        .NUM_SRC     (NS),
        .NUM_PARAM   (NP),
        .DATA_W      (DW),
        .SYNC_STAGES (2),
        .DRAIN_MAX   (10000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .src_start        (src_start),
        .src_stop         (src_stop),
        .param_req_tgl    (param_req_tgl),
        .param_data_async (param_data_async),
        .cycle_done       (cycle_done),
        .pulse_busy       (pulse_busy),
        .fault_in         (fault_in),
        .fault_clr        (fault_clr),
        .is_machine       (is_machine),
        .param_active     (param_active),
        .param_pending    (param_pending),
        .state            (state),
        .fault_latched    (fault_latched),
        .drain_timeout    (drain_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_STATE: return 32'(state);
            K_MACH:  return 32'(is_machine);
            K_ACT:   return 32'(param_active[idx*DW +: DW]);
            K_PEND:  return 32'(param_pending);
            K_FLT:   return 32'(fault_latched);
            default: return 32'(drain_timeout);
        endcase
    endfunction

    // Queue an expectation d cycles from now, kept sorted by due cycle.
    task automatic exp_chk(input string name, input int kind, input int idx,
                           input logic [31:0] val, input int unsigned d);
        exp_t e;
        int   pos;
        e.name = name; e.at = cyc + d; e.kind = kind; e.idx = idx; e.val = val;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].at > e.at) pos--;
        sb.insert(pos, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            got = actual(cur.kind, cur.idx);
            checks++;
            if (cur.at != cyc || got !== cur.val) begin
                failures++;
                $display("FAIL %s cycle=%0d due=%0d got=0x%0h expected=0x%0h",
                         cur.name, cyc, cur.at, got, cur.val);
            end
        end
    end

    initial begin
        rst_n = 1'b0; src_start = '0; src_stop = '0; param_req_tgl = '0;
        param_data_async = '0; cycle_done = 1'b0; pulse_busy = 1'b0;
        fault_in = 1'b0; fault_clr = 1'b0;
        vals = '{16'h0064, 16'h00C8, 16'h000F, 16'h0001};
        tick(2);
        exp_chk("rst_state", K_STATE, 0, 0, 0);
        exp_chk("rst_mach", K_MACH, 0, 0, 0);
        exp_chk("rst_pend", K_PEND, 0, 0, 0);
        exp_chk("rst_flt", K_FLT, 0, 0, 0);
        exp_chk("rst_dto", K_DTO, 0, 0, 0);
        for (int i = 0; i < 4; i++) exp_chk("rst_act", K_ACT, i, 0, 0);
        rst_n = 1'b1;
        tick(1);

        // Parameter load in IDLE: captured after 3 cycles, applied on the 4th.
        for (int i = 0; i < 4; i++) begin
            param_data_async[i*DW +: DW] = vals[i];
            param_req_tgl[i] = ~param_req_tgl[i];
            exp_chk("load_pend_set", K_PEND, 0, 32'(1 << i), 3);
            exp_chk("load_act_old", K_ACT, i, 0, 3);
            exp_chk("load_act_new", K_ACT, i, 32'(vals[i]), 4);
            exp_chk("load_pend_clr", K_PEND, 0, 0, 4);
            tick(5);
        end

        src_start = 2'b01;
        tick(1);
        src_start = '0;
        tick(2);
        exp_chk("one_src_idle", K_STATE, 0, 0, 0);
        exp_chk("one_src_mach", K_MACH, 0, 0, 0);
        src_start = 2'b10;
        exp_chk("start2_mach_prev", K_MACH, 0, 0, 1);
        exp_chk("start2_mach", K_MACH, 0, 1, 2);
        exp_chk("start2_state", K_STATE, 0, 1, 2);
        tick(1);
        src_start = '0;
        tick(2);

        // In RUN a new Ton waits for cycle_done.
        param_data_async[0 +: DW] = 16'h0032;
        param_req_tgl[0] = ~param_req_tgl[0];
        exp_chk("run_pend_set", K_PEND, 0, 1, 3);
        exp_chk("run_act_hold3", K_ACT, 0, 32'h0064, 3);
        exp_chk("run_act_hold6", K_ACT, 0, 32'h0064, 6);
        tick(6);
        cycle_done = 1'b1;
        exp_chk("run_act_apply", K_ACT, 0, 32'h0032, 1);
        exp_chk("run_pend_clr", K_PEND, 0, 0, 1);
        tick(1);
        cycle_done = 1'b0;
        tick(1);

        // Capture and apply on the same cycle for channel 1.
        param_data_async[DW +: DW] = 16'h00AA;
        param_req_tgl[1] = ~param_req_tgl[1];
        exp_chk("coll_pend_first", K_PEND, 0, 2, 3);
        tick(4);
        param_data_async[DW +: DW] = 16'h00BB;
        param_req_tgl[1] = ~param_req_tgl[1];
        tick(2);
        cycle_done = 1'b1;
        exp_chk("coll_act_old", K_ACT, 1, 32'h00AA, 1);
        exp_chk("coll_pend_keep", K_PEND, 0, 2, 1);
        tick(1);
        cycle_done = 1'b0;
        tick(1);
        cycle_done = 1'b1;
        exp_chk("coll_act_new", K_ACT, 1, 32'h00BB, 1);
        exp_chk("coll_pend_clr", K_PEND, 0, 0, 1);
        exp_chk("coll_still_run", K_STATE, 0, 1, 1);
        tick(1);
        cycle_done = 1'b0;
        tick(1);

        // Stop with the generator busy: drain timeout after 10000 cycles in STOPPING.
        pulse_busy = 1'b1;
        src_stop = 2'b10;
        exp_chk("stop_state_run", K_STATE, 0, 1, 1);
        exp_chk("stop_mach_run", K_MACH, 0, 1, 1);
        exp_chk("stop_state", K_STATE, 0, 2, 2);
        exp_chk("stop_mach", K_MACH, 0, 0, 2);
        exp_chk("drain_before", K_STATE, 0, 2, 10001);
        exp_chk("drain_dto_before", K_DTO, 0, 0, 10001);
        exp_chk("drain_idle", K_STATE, 0, 0, 10002);
        exp_chk("drain_dto", K_DTO, 0, 1, 10002);
        tick(1);
        src_stop = '0;
        tick(10003);
        pulse_busy = 1'b0;

        // Start and stop together on source 1 leaves it disabled.
        src_start = 2'b10;
        src_stop = 2'b10;
        exp_chk("startstop_state", K_STATE, 0, 0, 2);
        exp_chk("startstop_mach", K_MACH, 0, 0, 2);
        tick(1);
        src_start = '0;
        src_stop = '0;
        tick(2);
        src_start = 2'b10;
        exp_chk("restart_state", K_STATE, 0, 1, 2);
        exp_chk("restart_mach", K_MACH, 0, 1, 2);
        tick(1);
        src_start = '0;
        tick(2);

        // Fault handling.
        fault_in = 1'b1;
        exp_chk("fault_state", K_STATE, 0, 3, 1);
        exp_chk("fault_mach", K_MACH, 0, 0, 1);
        exp_chk("fault_flt", K_FLT, 0, 1, 1);
        tick(1);
        fault_clr = 1'b1;
        exp_chk("fault_clr_ignored", K_STATE, 0, 3, 1);
        tick(1);
        fault_clr = 1'b0;
        fault_in = 1'b0;
        tick(1);
        src_start = 2'b11;
        exp_chk("fault_start_ign", K_STATE, 0, 3, 2);
        tick(1);
        src_start = '0;
        tick(1);
        fault_clr = 1'b1;
        exp_chk("fault_exit", K_STATE, 0, 0, 1);
        exp_chk("fault_flt_clr", K_FLT, 0, 0, 1);
        exp_chk("fault_dto_clr", K_DTO, 0, 0, 1);
        tick(1);
        fault_clr = 1'b0;
        exp_chk("fault_stay_idle", K_STATE, 0, 0, 3);
        exp_chk("fault_stay_mach", K_MACH, 0, 0, 3);
        tick(3);
        src_start = 2'b11;
        exp_chk("fresh_state", K_STATE, 0, 1, 2);
        exp_chk("fresh_mach", K_MACH, 0, 1, 2);
        tick(1);
        src_start = '0;
        tick(2);

        // Asynchronous reset in RUN: checked before the next clock edge.
        rst_n = 1'b0;
        exp_chk("arst_state", K_STATE, 0, 0, 0);
        exp_chk("arst_mach", K_MACH, 0, 0, 0);
        exp_chk("arst_pend", K_PEND, 0, 0, 0);
        exp_chk("arst_flt", K_FLT, 0, 0, 0);
        for (int i = 0; i < 4; i++) exp_chk("arst_act", K_ACT, i, 0, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_unchecked left=%0d", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
